// File: rtl/prog_issuer.sv
// prog_issuer - instruction-issue front end for the ALU datapath.
//
// Holds a small loadable program of {opcd, in1, in2} words. It issues them
// one at a time over a valid/ready handshake and waits for each {resul, flag}
// response, which is logged per instruction index. A run stops on a HALT
// opcode, at the end of the program, or when a response times out.
//
// Ports:
//   fast_clk, rst         clock (rising edge), asynchronous active-high reset
//   start                 one-cycle run request (ignored while busy)
//   wr_en/wr_addr/wr_data program write port, {opcd, in1, in2}; ignored while busy
//   opcd/in1/in2          registered instruction fields presented to the datapath
//   issue_valid           instruction valid; issue_ready is the datapath accept
//   resul/flag/res_valid  datapath response, res_valid is a one-cycle strobe
//   i                     current instruction index (PC)
//   rd_addr/rd_data       combinational read of the {flag, resul} log
//   exec_count            instructions completed this run (saturating)
//   busy/done/err         run status; done and err hold until the next start
//   led                   flag of the most recently logged result
module prog_issuer #(
  parameter int               PROG_DEPTH = 8,
  parameter int               OPC_W      = 5,
  parameter int               OPD_W      = 2,
  parameter logic [OPC_W-1:0] HALT_OPC   = 5'h1F,
  parameter int               TIMEOUT    = 15
) (
  input  logic                              fast_clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              wr_en,
  input  logic [$clog2(PROG_DEPTH)-1:0]     wr_addr,
  input  logic [OPC_W+2*OPD_W-1:0]          wr_data,
  output logic [OPC_W-1:0]                  opcd,
  output logic [OPD_W-1:0]                  in1,
  output logic [OPD_W-1:0]                  in2,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  input  logic [OPD_W-1:0]                  resul,
  input  logic                              flag,
  input  logic                              res_valid,
  output logic [$clog2(PROG_DEPTH)-1:0]     i,
  input  logic [$clog2(PROG_DEPTH)-1:0]     rd_addr,
  output logic [OPD_W:0]                    rd_data,
  output logic [3:0]                        exec_count,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic                              led
);

  localparam int IDX_W  = $clog2(PROG_DEPTH);
  localparam int WORD_W = OPC_W + 2*OPD_W;
  localparam int TMR_W  = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [WORD_W-1:0] HALT_WORD = {HALT_OPC, {(2*OPD_W){1'b0}}};

  logic [2:0]        state_q, state_d;
  logic [OPC_W-1:0]  opcd_q, opcd_d;
  logic [OPD_W-1:0]  in1_q, in1_d;
  logic [OPD_W-1:0]  in2_q, in2_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [3:0]        exec_count_q, exec_count_d;
  logic              err_q, err_d;
  logic              led_q, led_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic [WORD_W-1:0] prog_q [PROG_DEPTH];
  logic [WORD_W-1:0] prog_d [PROG_DEPTH];
  logic [OPD_W:0]    log_q  [PROG_DEPTH];
  logic [OPD_W:0]    log_d  [PROG_DEPTH];

  logic [WORD_W-1:0] fetch_word;
  logic              timer_expire;

  assign busy         = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign fetch_word   = prog_q[i_q];
  // Last cycle of the timeout window: the timer has counted TIMEOUT-1 cycles
  // already, so leaving on this edge makes the window exactly TIMEOUT cycles.
  assign timer_expire = (timer_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    opcd_d       = opcd_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    i_d          = i_q;
    exec_count_d = exec_count_q;
    err_d        = err_q;
    led_d        = led_q;
    timer_d      = timer_q;
    prog_d       = prog_q;
    log_d        = log_q;

    if (wr_en && !busy) begin
      prog_d[wr_addr] = wr_data;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_FETCH;
          i_d          = '0;
          exec_count_d = '0;
          err_d        = 1'b0;
        end
      end
      S_FETCH: begin
        {opcd_d, in1_d, in2_d} = fetch_word;
        timer_d = '0;
        if (fetch_word[WORD_W-1 -: OPC_W] == HALT_OPC) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = timer_q + 1'b1;
        // Timeout wins over a coincident handshake; responses are ignored here.
        if (timer_expire) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (issue_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (res_valid) begin
          log_d[i_q] = {flag, resul};
          led_d      = flag;
          if (exec_count_q != 4'hF) begin
            exec_count_d = exec_count_q + 1'b1;
          end
          if (i_q == IDX_W'(PROG_DEPTH - 1)) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = S_FETCH;
          end
        end else if (timer_expire) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      opcd_q       <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      i_q          <= '0;
      exec_count_q <= '0;
      err_q        <= 1'b0;
      led_q        <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      opcd_q       <= opcd_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      i_q          <= i_d;
      exec_count_q <= exec_count_d;
      err_q        <= err_d;
      led_q        <= led_d;
      timer_q      <= timer_d;
    end
  end

  // Program and log storage are resettable registers (reset loads HALT into
  // every program slot), so they live in flops rather than block RAM.
  genvar gi;
  generate
    for (gi = 0; gi < PROG_DEPTH; gi++) begin : g_store
      always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
          prog_q[gi] <= HALT_WORD;
          log_q[gi]  <= '0;
        end else begin
          prog_q[gi] <= prog_d[gi];
          log_q[gi]  <= log_d[gi];
        end
      end
    end
  endgenerate

  assign opcd        = opcd_q;
  assign in1         = in1_q;
  assign in2         = in2_q;
  assign issue_valid = (state_q == S_ISSUE);
  assign i           = i_q;
  assign rd_data     = log_q[rd_addr];
  assign exec_count  = exec_count_q;
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign led         = led_q;

endmodule

// File: tb/tb_prog_issuer.sv
// tb_prog_issuer - directed self-checking bench for prog_issuer.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_prog_issuer;

  logic       fast_clk;
  logic       rst;
  logic       start;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [8:0] wr_data;
  logic [4:0] opcd;
  logic [1:0] in1;
  logic [1:0] in2;
  logic       issue_valid;
  logic       issue_ready;
  logic [1:0] resul;
  logic       flag;
  logic       res_valid;
  logic [2:0] i;
  logic [2:0] rd_addr;
  logic [2:0] rd_data;
  logic [3:0] exec_count;
  logic       busy;
  logic       done;
  logic       err;
  logic       led;

  // Datapath response: manual values, or an automatic model resul=in1+in2,
  // flag set only for opcode 0x0F.
  logic       resp_auto;
  logic [1:0] resul_man;
  logic       flag_man;

  int checks;
  int errors;

  // Results of the last run_until_done call.
  int         run_cycles;
  int         run_issues;
  logic [4:0] seen_opcd;
  logic [1:0] seen_in1;
  logic [1:0] seen_in2;

  prog_issuer dut (
    .fast_clk    (fast_clk),
    .rst         (rst),
    .start       (start),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .opcd        (opcd),
    .in1         (in1),
    .in2         (in2),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .resul       (resul),
    .flag        (flag),
    .res_valid   (res_valid),
    .i           (i),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .exec_count  (exec_count),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .led         (led)
  );

  initial fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  always_comb begin
    resul = resul_man;
    flag  = flag_man;
    if (resp_auto) begin
      resul = in1 + in2;
      flag  = (opcd == 5'h0F);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge fast_clk);
    #1;
  endtask

  task automatic write_prog(input logic [2:0] addr, input logic [8:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs until done, counting cycles with issue_valid high and capturing the
  // first issued instruction. An exhausted budget is a failed comparison.
  task automatic run_until_done(input int budget);
    run_cycles = 0;
    run_issues = 0;
    while (!done && run_cycles < budget) begin
      if (issue_valid) begin
        if (run_issues == 0) begin
          seen_opcd = opcd;
          seen_in1  = in1;
          seen_in2  = in2;
        end
        run_issues++;
      end
      tick();
      run_cycles++;
    end
    if (!done) check_val("run_budget_done", 32'(done), 32'd1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    start       = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    issue_ready = 1'b0;
    res_valid   = 1'b0;
    rd_addr     = '0;
    resp_auto   = 1'b0;
    resul_man   = '0;
    flag_man    = 1'b0;
    seen_opcd   = '0;
    seen_in1    = '0;
    seen_in2    = '0;
    run_cycles  = 0;
    run_issues  = 0;

    // ---- Power-on reset state ----
    repeat (2) tick();
    check_val("por_busy", 32'(busy), 32'd0);
    check_val("por_done", 32'(done), 32'd0);
    check_val("por_issue_valid", 32'(issue_valid), 32'd0);
    rst = 1'b0;
    tick();

    // ---- Single instruction then HALT ----
    write_prog(3'd0, {5'h01, 2'd1, 2'd2});
    write_prog(3'd1, {5'h1F, 2'd0, 2'd0});
    issue_ready = 1'b1;
    res_valid   = 1'b1;
    resul_man   = 2'd3;
    flag_man    = 1'b0;
    pulse_start();
    run_until_done(40);
    check_val("single_issues", 32'(run_issues), 32'd1);
    check_val("single_opcd", 32'(seen_opcd), 32'h01);
    check_val("single_in1", 32'(seen_in1), 32'd1);
    check_val("single_in2", 32'(seen_in2), 32'd2);
    check_val("single_exec_count", 32'(exec_count), 32'd1);
    check_val("single_i", 32'(i), 32'd1);
    check_val("single_err", 32'(err), 32'd0);
    check_val("single_busy", 32'(busy), 32'd0);
    rd_addr = 3'd0;
    #1;
    check_val("single_log0", 32'(rd_data), 32'b011);

    // ---- Full 8-entry program, no HALT ----
    // Entry k: opcd = 8+k, in1 = k[1:0], in2 = k[2:1]; only entry 7 has opcd 0x0F.
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kk;
      kk = 3'(k);
      write_prog(kk, {5'(8 + k), kk[1:0], kk[2:1]});
    end
    resp_auto = 1'b1;
    pulse_start();
    run_until_done(100);
    check_val("full_issues", 32'(run_issues), 32'd8);
    check_val("full_i", 32'(i), 32'd7);
    check_val("full_exec_count", 32'(exec_count), 32'd8);
    check_val("full_led", 32'(led), 32'd1);
    check_val("full_done", 32'(done), 32'd1);
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kk;
      logic [1:0] sum;
      kk      = 3'(k);
      sum     = kk[1:0] + kk[2:1];
      rd_addr = kk;
      #1;
      check_val($sformatf("full_log%0d", k), 32'(rd_data), 32'({(k == 7), sum}));
    end
    resp_auto = 1'b0;

    // ---- issue_ready held low for 5 cycles ----
    write_prog(3'd0, {5'h02, 2'd3, 2'd1});
    write_prog(3'd1, {5'h1F, 2'd0, 2'd0});
    issue_ready = 1'b0;
    res_valid   = 1'b0;
    pulse_start();           // now in FETCH
    tick();                  // now in ISSUE
    for (int c = 0; c < 5; c++) begin
      check_val($sformatf("stall_valid_c%0d", c), 32'(issue_valid), 32'd1);
      check_val($sformatf("stall_opcd_c%0d", c), 32'(opcd), 32'h02);
      tick();
    end
    issue_ready = 1'b1;
    tick();                  // accepted, now in WAIT
    check_val("stall_valid_after_accept", 32'(issue_valid), 32'd0);
    issue_ready = 1'b0;
    resul_man   = 2'd1;
    flag_man    = 1'b1;
    res_valid   = 1'b1;
    tick();
    res_valid   = 1'b0;
    run_until_done(20);
    check_val("stall_err", 32'(err), 32'd0);
    check_val("stall_exec_count", 32'(exec_count), 32'd1);
    check_val("stall_led", 32'(led), 32'd1);
    rd_addr = 3'd0;
    #1;
    check_val("stall_log0", 32'(rd_data), 32'b101);

    // ---- Response timeout ----
    write_prog(3'd0, {5'h03, 2'd1, 2'd1});
    issue_ready = 1'b1;
    res_valid   = 1'b0;
    pulse_start();           // FETCH
    tick();                  // entered ISSUE
    begin
      int n;
      n = 0;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      check_val("timeout_cycles", 32'(n), 32'd15);
    end
    check_val("timeout_err", 32'(err), 32'd1);
    check_val("timeout_done", 32'(done), 32'd1);
    check_val("timeout_issue_valid", 32'(issue_valid), 32'd0);
    check_val("timeout_exec_count", 32'(exec_count), 32'd0);
    rd_addr = 3'd0;
    #1;
    check_val("timeout_log0_kept", 32'(rd_data), 32'b101);

    // ---- Restart from DONE, write and start while busy ----
    write_prog(3'd0, {5'h04, 2'd2, 2'd2});
    resul_man = 2'd2;
    flag_man  = 1'b0;
    res_valid = 1'b1;
    pulse_start();           // FETCH
    check_val("restart_err_cleared", 32'(err), 32'd0);
    check_val("restart_done_cleared", 32'(done), 32'd0);
    check_val("restart_i", 32'(i), 32'd0);
    wr_en   = 1'b1;
    wr_addr = 3'd1;
    wr_data = {5'h05, 2'd1, 2'd1};
    start   = 1'b1;
    tick();
    wr_en   = 1'b0;
    start   = 1'b0;
    run_until_done(40);
    check_val("busy_run_exec_count", 32'(exec_count), 32'd1);
    check_val("busy_run_i", 32'(i), 32'd1);
    rd_addr = 3'd0;
    #1;
    check_val("busy_run_log0", 32'(rd_data), 32'b010);
    pulse_start();
    run_until_done(40);
    check_val("rerun_prog1_still_halt", 32'(exec_count), 32'd1);

    // ---- Reset mid-WAIT at i=3 ----
    for (int k = 0; k < 4; k++) write_prog(3'(k), {5'(k + 1), 2'd1, 2'd0});
    resul_man = 2'd1;
    flag_man  = 1'b1;
    res_valid = 1'b1;
    pulse_start();
    begin
      int n;
      n = 0;
      while (i != 3'd3 && n < 30) begin
        tick();
        n++;
      end
    end
    res_valid = 1'b0;        // i just became 3, in FETCH
    tick();                  // ISSUE
    tick();                  // WAIT
    check_val("pre_reset_i", 32'(i), 32'd3);
    check_val("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("rst_outputs", 32'({opcd, in1, in2, issue_valid, i, exec_count, busy, done, err, led}), 32'd0);
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      #1;
      check_val($sformatf("rst_log%0d", k), 32'(rd_data), 32'd0);
    end
    tick();
    rst = 1'b0;
    tick();
    pulse_start();           // FETCH
    tick();                  // HALT -> DONE
    check_val("rst_prog_halt_done", 32'(done), 32'd1);
    check_val("rst_prog_exec_count", 32'(exec_count), 32'd0);
    check_val("rst_prog_i", 32'(i), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
